headgen_seq_engine: RTL and testbench
=====================================

Name: headgen_seq_engine

Overview:
- Microcode-sequenced header generator; successor to the single-word static/dynamic output mux in the EtherBlade header path.
- Holds a small microcode program store, steps through one header program per start request and resolves each word to static data or to one of DYN_CH snapshotted dynamic sources.
- Emits the header as a byte stream with valid/ready toward the frame assembler.

Parameters:
- DATA_W, 8, width of static field, dynamic sources and output data.
- DYN_CH, 4, number of dynamic sources; power of two, 2..2^DATA_W.
- PROG_DEPTH, 64, microcode store depth in words; power of two.
- ADDR_W, $clog2(PROG_DEPTH), program address width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- prog_we  in  1  microcode store write strobe.
- prog_addr  in  ADDR_W  write address.
- prog_wdata  in  DATA_W+2  microcode word {last, final_sel, static[DATA_W-1:0]}.
- start  in  1  start request pulse.
- start_addr  in  ADDR_W  first program word of the header.
- dyndata_in  in  DYN_CH*DATA_W  flattened dynamic sources; channel k at [k*DATA_W +: DATA_W].
- out_data  out  DATA_W  header byte.
- out_valid  out  1  out_data valid.
- out_last  out  1  final byte of header.
- out_ready  in  1  downstream accept.
- busy  out  1  header in progress.
- done  out  1  one-cycle pulse after last byte accepted.
- err  out  1  sticky error flag.

Behaviour:
- Clocking/reset: one clock, clk; reset rst_n is synchronous and active-low. On rst_n=0: state IDLE, pc=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, err=0. Program store contents are not reset.
- Word decode: final_sel=1 -> out_data = snapshot[static[SEL_W-1:0]], with SEL_W=$clog2(DYN_CH). final_sel=0 -> out_data = static.
- States: IDLE, RUN.
- IDLE + start: capture all dyndata_in into the snapshot register, load pc=start_addr, go to RUN, set busy.
  - Dynamic data is frozen for the whole header; later changes on dyndata_in have no effect.
- Latency: start sampled at edge N; first word on out_data with out_valid=1 after edge N+1.
- RUN: out_data, out_valid and out_last are registered. Outputs hold stable while out_valid && !out_ready.
  - On accept (out_valid && out_ready), pc increments and the next word is loaded. Sustained out_ready gives one byte per cycle with no bubbles.
- Accepting a word with last=1 leaves RUN for IDLE: out_valid=0, busy=0, done=1 for one cycle.
- Wrap: if pc would pass PROG_DEPTH-1 without last=1, the word at PROG_DEPTH-1 is forced out_last=1, err is set, and the engine returns to IDLE normally. The address never wraps to 0.
- start while busy: ignored, err set.
- prog_we while busy: write dropped, err set.
- prog_we in IDLE: store written; a start in the same cycle reads the old contents.
- err clears only on reset.
- Reset mid-header: stream aborts immediately; no done pulse.

Optional Feature:
- HEADGEN_CHKSUM_EN defined:
  - After the last program word, one extra byte is emitted: the XOR of all header bytes.
  - The program word is sent with out_last=0; the checksum byte carries out_last=1.
  - done follows acceptance of the checksum byte.
  - Total header length is program length + 1.
- Undefined: no checksum logic; the last program word carries out_last=1.

Decomposition:
- Shared package/header headgen_pkg:
  - microcode bit positions: LAST_BIT=DATA_W+1, FSEL_BIT=DATA_W;
  - state encodings ST_IDLE=1'b0, ST_RUN=1'b1;
  - SEL_W derivation.
- Sub-module headgen_word_resolve: combinational decode of one microcode word plus snapshot into a byte. It is the parametrised DYN_CH-way replacement of the original mux.
- Engine handles sequencing, handshake and errors.

Test Plan:
- Program addr0={0,0,0x55}, addr1={0,1,0x02}, addr2={1,0,0xAA}; dyndata ch2=0x3C; start_addr=0, out_ready=1 -> bytes 0x55,0x3C,0xAA on consecutive cycles; out_last on 0xAA; done one cycle later; err=0.
- Same program; ch2 changed to 0xFF one cycle after start -> second byte still 0x3C.
- out_ready low for 3 cycles while byte 0x3C is presented -> out_data/out_valid held stable; no skip, no duplicate.
- start_addr=PROG_DEPTH-2 with no last bit -> 2 bytes, forced out_last on second, err=1, busy drops.
- start and prog_we mid-header -> both ignored, stream unchanged, err=1; rst_n=0 mid-header -> out_valid=0 next cycle, no done.
- HEADGEN_CHKSUM_EN defined, test 1 program -> 4 bytes, final 0x55^0x3C^0xAA=0xC3 with out_last=1.

Source files
------------

// File: rtl/headgen_pkg.sv
// headgen_pkg: shared encodings for the microcode header generator.
// Optional checksum byte is enabled with HEADGEN_CHKSUM_EN.
package headgen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int last_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int fsel_bit(input int dw);
    return dw;
  endfunction

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/headgen_word_resolve.sv
// headgen_word_resolve: turns one microcode word plus the
// snapshot of dynamic sources into an output byte.
module headgen_word_resolve
  import headgen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DYN_CH = 4
) (
  input  logic [DATA_W+1:0]        word_i,
  input  logic [DYN_CH*DATA_W-1:0] snap_i,
  output logic [DATA_W-1:0]        byte_o
);

  localparam int SW = sel_w(DYN_CH);
  localparam int FB = fsel_bit(DATA_W);
  localparam int LB = last_bit(DATA_W);

  logic [SW-1:0] sel;
  logic          unused_last;

  assign sel         = word_i[SW-1:0];
  assign unused_last = word_i[LB];

  always_comb begin
    byte_o = word_i[DATA_W-1:0];
    unique case (1'b1)
      word_i[FB]: byte_o = snap_i[sel*DATA_W +: DATA_W];
      default:    byte_o = word_i[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/headgen_seq_engine.sv
// headgen_seq_engine: steps a microcode header program and streams
// bytes with valid/ready. HEADGEN_CHKSUM_EN appends an XOR byte.
module headgen_seq_engine
  import headgen_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DYN_CH     = 4,
  parameter int PROG_DEPTH = 64,
  parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [DATA_W+1:0]        prog_wdata,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [DYN_CH*DATA_W-1:0] dyndata_in,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int WW = DATA_W + 2;
  localparam int LB = last_bit(DATA_W);

  logic [WW-1:0]            mem_q [PROG_DEPTH];
  state_e                   state_q;
  logic [ADDR_W-1:0]        pc_q;
  logic [WW-1:0]            word_q;
  logic [DYN_CH*DATA_W-1:0] snap_q;
  logic [DATA_W-1:0]        out_data_q;
  logic [DATA_W-1:0]        csum_q;
  logic                     out_valid_q;
  logic                     out_last_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;
  logic                     end_q;

  logic [ADDR_W-1:0]        pc_d;
  logic [WW-1:0]            word_d;
  logic [DATA_W-1:0]        byte_d;
  logic                     at_top;
  logic                     last_d;
  logic                     accept;
  logic                     run;

  assign run    = (state_q == ST_RUN);
  assign accept = out_valid_q & out_ready;

  // First word comes from word_q so a same-cycle write cannot leak in.
  always_comb begin
    pc_d   = out_valid_q ? pc_q + 1'b1 : pc_q;
    word_d = out_valid_q ? mem_q[pc_d] : word_q;
    at_top = (pc_d == ADDR_W'(PROG_DEPTH - 1));
    last_d = word_d[LB] | at_top;
  end

  headgen_word_resolve #(
    .DATA_W (DATA_W),
    .DYN_CH (DYN_CH)
  ) u_resolve (
    .word_i (word_d),
    .snap_i (snap_q),
    .byte_o (byte_d)
  );

  always_ff @(posedge clk) begin
    if (rst_n && prog_we && !run) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      word_q      <= '0;
      snap_q      <= '0;
      out_data_q  <= '0;
      csum_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (run && (start || prog_we)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            snap_q  <= dyndata_in;
            pc_q    <= start_addr;
            word_q  <= mem_q[start_addr];
            csum_q  <= '0;
            end_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!out_valid_q || accept) begin
            if (out_valid_q && out_last_q) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
`ifdef HEADGEN_CHKSUM_EN
            else if (out_valid_q && end_q) begin
              out_data_q <= csum_q ^ out_data_q;
              out_last_q <= 1'b1;
            end
`endif
            else begin
              pc_q        <= pc_d;
              out_data_q  <= byte_d;
              out_valid_q <= 1'b1;
              end_q       <= last_d;
              if (out_valid_q) begin
                csum_q <= csum_q ^ out_data_q;
              end
              if (at_top && !word_d[LB]) begin
                err_q <= 1'b1;
              end
`ifdef HEADGEN_CHKSUM_EN
              out_last_q <= 1'b0;
`else
              out_last_q <= last_d;
`endif
            end
          end
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_headgen_seq_engine.sv
// tb_headgen_seq_engine: scoreboard bench with a header-level model
// of program walking, snapshot decode, wrap and optional checksum.
module tb_headgen_seq_engine;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int PD = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW+1:0] prog_wdata;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [NC*DW-1:0] dyndata_in;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err;

  headgen_seq_engine #(
    .DATA_W     (DW),
    .DYN_CH     (NC),
    .PROG_DEPTH (PD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .start      (start),
    .start_addr (start_addr),
    .dyndata_in (dyndata_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] mem_m [PD];
  logic [8:0] sbq [$];
  logic       err_exp = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Model: walk words from sa until last or top of store.
  task automatic push_header(input int sa, input logic [31:0] snap,
                             output int len);
    logic [9:0] w;
    logic [7:0] b;
    logic [7:0] cs;
    logic       l;
    cs  = 8'h00;
    len = 0;
    for (int a = sa; a < PD; a++) begin
      w = mem_m[a];
      b = w[8] ? snap[w[1:0]*8 +: 8] : w[7:0];
      l = w[9] || (a == PD - 1);
      if (a == PD - 1 && !w[9]) err_exp = 1'b1;
      cs = cs ^ b;
      len++;
`ifdef HEADGEN_CHKSUM_EN
      sbq.push_back({1'b0, b});
      if (l) begin
        sbq.push_back({1'b1, cs});
        len++;
      end
`else
      sbq.push_back({l, b});
`endif
      if (l) break;
    end
  endtask

  logic       prev_stall = 1'b0;
  logic       prev_lacc  = 1'b0;
  logic [8:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_lacc  = 1'b0;
    end else begin
      check("done_pulse", {31'd0, done}, {31'd0, prev_lacc});
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {23'd0, out_last, out_data}, {23'd0, held});
      end
      prev_lacc = 1'b0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("extra_byte", {23'd0, out_last, out_data}, 32'h1ff);
        end else begin
          check("byte", {23'd0, out_last, out_data},
                {23'd0, sbq.pop_front()});
        end
        prev_lacc = out_last;
      end
      prev_stall = out_valid && !out_ready;
      held       = {out_last, out_data};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    sbq.delete();
    err_exp = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    tick();
  endtask

  task automatic write(input int a, input logic [9:0] w);
    prog_we    = 1'b1;
    prog_addr  = AW'(a);
    prog_wdata = w;
    tick();
    prog_we = 1'b0;
    mem_m[a] = w;
  endtask

  // mode 0: ready high, 1: random ready, 2: stall cycles 2..4.
  // pert: start + write mid-header. wsame: write sa with start.
  task automatic run_header(input int sa, input int mode,
                            input bit pert, input bit wsame,
                            input logic [9:0] wval, input bit ch2ff);
    int len;
    int cnt;
    bit got;
    push_header(sa, dyndata_in, len);
    start      = 1'b1;
    start_addr = AW'(sa);
    if (wsame) begin
      prog_we    = 1'b1;
      prog_addr  = AW'(sa);
      prog_wdata = wval;
      mem_m[sa]  = wval;
    end
    out_ready = 1'b1;
    tick();
    start   = 1'b0;
    prog_we = 1'b0;
    dyndata_in = $urandom;
    if (ch2ff) dyndata_in[23:16] = 8'hFF;
    got = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      unique case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = !(cnt >= 2 && cnt <= 4);
      endcase
      if (pert && cnt == 2) begin
        start      = 1'b1;
        start_addr = AW'($urandom);
        prog_we    = 1'b1;
        prog_addr  = AW'(sa + 2);
        prog_wdata = 10'h0EE;
        err_exp    = 1'b1;
      end else begin
        start   = 1'b0;
        prog_we = 1'b0;
      end
      @(negedge clk);
      if (cnt == 0) check("busy_run", {31'd0, busy}, 32'd1);
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
      cnt++;
    end
    start   = 1'b0;
    prog_we = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
    if (mode == 0) check("latency", cnt, len + 1);
    tick();
    @(negedge clk);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("err", {31'd0, err}, {31'd0, err_exp});
    check("sb_empty", sbq.size(), 32'd0);
    tick();
  endtask

  initial begin
    int len;
    rst_n      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    start      = 1'b0;
    start_addr = '0;
    dyndata_in = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < PD; i++) mem_m[i] = 10'h200;
    do_reset();
    for (int i = 0; i < PD; i++) write(i, 10'h200);

    write(0, 10'h055);
    write(1, 10'h102);
    write(2, 10'h2AA);
    dyndata_in = $urandom;
    dyndata_in[23:16] = 8'h3C;
    run_header(0, 0, 1'b0, 1'b0, 10'h0, 1'b0);
    dyndata_in[23:16] = 8'h3C;
    run_header(0, 0, 1'b0, 1'b0, 10'h0, 1'b1);
    dyndata_in[23:16] = 8'h3C;
    run_header(0, 2, 1'b0, 1'b0, 10'h0, 1'b0);
    run_header(0, 1, 1'b0, 1'b1, 10'h211, 1'b0);
    run_header(0, 0, 1'b0, 1'b0, 10'h0, 1'b0);

    write(62, 10'h0A1);
    write(63, 10'h103);
    run_header(62, 0, 1'b0, 1'b0, 10'h0, 1'b0);

    do_reset();
    write(0, 10'h055);
    dyndata_in[23:16] = 8'h3C;
    run_header(0, 0, 1'b1, 1'b0, 10'h0, 1'b0);

    push_header(0, dyndata_in, len);
    start = 1'b1;
    start_addr = '0;
    tick();
    start = 1'b0;
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done", {31'd0, done}, 32'd0);
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end

    for (int i = 0; i < PD; i++) begin
      write(i, {($urandom_range(0, 3) == 0), 9'($urandom)});
    end
    for (int n = 0; n < 25; n++) begin
      dyndata_in = $urandom;
      run_header($urandom_range(0, PD - 1), $urandom_range(0, 1),
                 1'b0, 1'b0, 10'h0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
